spi_responder: RTL and testbench
================================

Name: spi_responder

Overview:
- SPI target (slave) that answers the board's bit-banged SPI initiator: SCK, MOSI and one nSS line in, MISO out.
- Oversamples the slow SPI lines with the system clock. Deserialises MOSI into bytes with a valid/ack handshake.
- Serialises MISO bytes from a small TX FIFO.
- Used as an on-board SPI device: a loopback or emulated peripheral on one of the nSS/MISO lanes.

Parameters:
- CPOL, 0, SCK idle level. Sampling happens on the leading edge (CPHA=0 only): rising when CPOL=0, falling when CPOL=1.
- TXLOG2, 2, log2 of TX FIFO depth (default 4 entries).
- FILL, 8'hFF, byte shifted out when the TX FIFO is empty at byte load.

Ports:
- CLK  in  1  system clock; must be at least 8x SCK frequency.
- nRESET  in  1  synchronous active-low reset, sampled on posedge CLK.
- SCK  in  1  SPI clock from initiator, asynchronous.
- MOSI  in  1  SPI data from initiator, asynchronous.
- nSS  in  1  active-low select from initiator, asynchronous.
- MISO  out  1  SPI data to initiator.
- MISO_OE  out  1  MISO output enable; pad is tristated when 0.
- RXD  out  8  last received byte.
- RXVALID  out  1  RXD holds an unread byte.
- RXACK  in  1  one-cycle pulse; consumes RXD.
- TXD  in  8  byte to enqueue.
- TXWR  in  1  one-cycle enqueue strobe.
- TXFULL  out  1  FIFO full; TXWR is ignored while set.
- TXLEVEL  out  TXLOG2+1  FIFO occupancy.
- OVR  out  1  sticky: receive overrun.
- UDR  out  1  sticky: transmit underrun (FILL was sent).
- CLRFLAGS  in  1  one-cycle pulse; clears OVR and UDR.
- SELECTED  out  1  synchronised nSS is low.
- FRAMEEND  out  1  one-cycle pulse on synchronised nSS rising edge.

Behaviour:
- Reset (nRESET=0 at posedge CLK):
  - Outputs: MISO=1, MISO_OE=0, RXVALID=0, RXD=0, TXLEVEL=0, TXFULL=0, OVR=0, UDR=0, SELECTED=0, FRAMEEND=0.
  - Internal state: FIFO pointers=0, bit counter=0, shift registers=0.
  - Synchroniser flops reset to the idle levels nSS=1, SCK=CPOL, MOSI=0.
  - If nSS is already low when reset is released, the first clocks see a falling edge and a new frame starts.
- Synchronisation and latency:
  - SCK, MOSI and nSS each pass through two flops, then a third flop for edge detection.
  - Each line edge is acted on 3 CLK after it arrives.
  - MISO changes 1 CLK after the detected edge, so the total is at most 4 CLK after the SCK edge.
- State machine, IDLE -> SHIFT:
  - IDLE: MISO_OE=0. Wait for the synchronised nSS falling edge.
  - On that edge: load the TX byte, drive MISO=byte[7], MISO_OE=1, bit counter=0, go to SHIFT.
  - SHIFT, leading SCK edge: rxshift <= {rxshift[6:0], MOSI}; bitcnt++.
  - When bitcnt becomes 8, a byte is complete:
    - RXVALID=0: RXD <= {rxshift[6:0],MOSI}, RXVALID <= 1.
    - RXVALID=1: new byte is discarded, RXD is kept, OVR <= 1.
    - bitcnt <= 0 and a reload flag is set.
  - SHIFT, trailing SCK edge:
    - Reload flag set: load the next TX byte, MISO = byte[7], clear the flag.
    - Otherwise: txshift <<= 1, MISO = new txshift[7].
  - Synchronised nSS rising edge in SHIFT: go to IDLE.
    - MISO_OE <= 0, FRAMEEND pulses, bitcnt <= 0, reload flag cleared.
    - A partial byte is discarded: RXVALID and RXD are not touched.
    - A byte already popped from the FIFO is lost; TXLEVEL is not restored.
  - SCK edges in IDLE are ignored.
  - nSS falling and an SCK edge detected in the same CLK: the frame start is processed first and that SCK edge is ignored.
- TX byte load:
  - FIFO non-empty: pop the head.
  - FIFO empty: use FILL and set UDR <= 1.
  - TXWR in the same cycle as a pop:
    - Empty FIFO: the pop sees empty (FILL is sent) and the write is enqueued.
    - Full FIFO: TXFULL is evaluated before the pop, so the write is dropped.
  - TXLEVEL is the write count minus the pop count, range 0..2^TXLOG2. TXFULL = (TXLEVEL == 2^TXLOG2).
- RX handshake:
  - RXACK with RXVALID=1: RXVALID <= 0 next cycle.
  - RXACK and byte completion in the same CLK: RXVALID stays 1, RXD takes the new byte, OVR is not set.
  - RXACK with RXVALID=0: no effect.
- Flags:
  - CLRFLAGS clears OVR and UDR.
  - A set event and CLRFLAGS in the same cycle: set wins.
- SELECTED is the synchronised nSS, inverted.

Test Plan:
1. CPOL=0: FIFO holds 0xA5. Initiator frames one byte 0x3C, SCK period 16 CLK. Required: MISO bits 1,0,1,0,0,1,0,1; RXD=0x3C with RXVALID=1; TXLEVEL back to 0; UDR=0; FRAMEEND pulses once after nSS rises.
2. Back-to-back bytes 0x01, 0x02, 0x03 in one frame. FIFO preloaded with 0x11 and 0x22. Required: MISO carries 0x11, 0x22, 0xFF; UDR=1 after byte 3. With RXACK given after each byte, RXD sequence is 0x01, 0x02, 0x03.
3. No RXACK, two bytes 0x55 then 0xAA. Required: RXD=0x55, OVR=1. After CLRFLAGS, OVR=0. RXACK and completion in the same cycle gives RXD updated and OVR=0.
4. nSS deasserted after 5 SCK cycles. Required: RXVALID unchanged, MISO_OE=0 within 4 CLK. Next frame of byte 0x7E receives exactly 0x7E.
5. Five TXWR of 0x10..0x14 with no frame active. Required: TXLEVEL=4, TXFULL=1, 0x14 dropped. A subsequent 4-byte frame returns 0x10..0x13.
6. nRESET pulsed low mid-byte with nSS held low. Required: all outputs at reset values. On release, a new frame starts and the next 8 SCK cycles receive a complete byte. Repeat test 1 with CPOL=1 and SCK idling high: identical data.

Source files
------------

// File: rtl/spi_responder.sv
// SPI target (CPHA=0) for the board's bit-banged initiator: oversampled SCK/MOSI/nSS,
// MOSI bytes out through a valid/ack handshake, MISO bytes taken from a small TX FIFO.
module spi_responder #(
    parameter bit              CPOL   = 1'b0,
    parameter int unsigned     TXLOG2 = 2,
    parameter logic [7:0]      FILL   = 8'hFF
) (
    input  logic              CLK,
    input  logic              nRESET,
    input  logic              SCK,
    input  logic              MOSI,
    input  logic              nSS,
    output logic              MISO,
    output logic              MISO_OE,
    output logic [7:0]        RXD,
    output logic              RXVALID,
    input  logic              RXACK,
    input  logic [7:0]        TXD,
    input  logic              TXWR,
    output logic              TXFULL,
    output logic [TXLOG2:0]   TXLEVEL,
    output logic              OVR,
    output logic              UDR,
    input  logic              CLRFLAGS,
    output logic              SELECTED,
    output logic              FRAMEEND
);

    localparam int unsigned     DEPTH   = 1 << TXLOG2;
    localparam logic [TXLOG2:0] DEPTH_L = {1'b1, {TXLOG2{1'b0}}};

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state;
    logic [2:0]        sck_sy;
    logic [2:0]        mosi_sy;
    logic [2:0]        nss_sy;
    logic [2:0]        bitcnt;
    logic              reload;
    logic [6:0]        rxshift;
    logic [6:0]        txshift;

    logic [7:0]        mem [DEPTH];
    logic [TXLOG2-1:0] wr_ptr;
    logic [TXLOG2-1:0] rd_ptr;
    logic [TXLOG2:0]   level;

    logic              sck_edge;
    logic              lead;
    logic              trail;
    logic              nss_fall;
    logic              nss_rise;
    logic              mosi_bit;
    logic              load_req;
    logic              empty;
    logic              push;
    logic              pop;
    logic [7:0]        load_byte;

    always_comb begin
        sck_edge  = sck_sy[1] ^ sck_sy[2];
        lead      = sck_edge && (sck_sy[1] != CPOL);
        trail     = sck_edge && (sck_sy[1] == CPOL);
        nss_fall  = !nss_sy[1] && nss_sy[2];
        nss_rise  = nss_sy[1] && !nss_sy[2];
        mosi_bit  = mosi_sy[2];
        // A frame start outranks any SCK edge seen in the same cycle.
        load_req  = ((state == IDLE) && nss_fall)
                 || ((state == SHIFT) && !nss_rise && trail && reload);
        empty     = (level == '0);
        push      = TXWR && !TXFULL;
        pop       = load_req && !empty;
        load_byte = empty ? FILL : mem[rd_ptr];
    end

    assign TXLEVEL  = level;
    assign TXFULL   = (level == DEPTH_L);
    assign SELECTED = !nss_sy[2];

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            sck_sy  <= {3{CPOL}};
            mosi_sy <= '0;
            nss_sy  <= '1;
        end else begin
            sck_sy  <= {sck_sy[1:0], SCK};
            mosi_sy <= {mosi_sy[1:0], MOSI};
            nss_sy  <= {nss_sy[1:0], nSS};
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= TXD;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            state    <= IDLE;
            MISO     <= 1'b1;
            MISO_OE  <= 1'b0;
            RXD      <= '0;
            RXVALID  <= 1'b0;
            OVR      <= 1'b0;
            UDR      <= 1'b0;
            FRAMEEND <= 1'b0;
            bitcnt   <= '0;
            reload   <= 1'b0;
            rxshift  <= '0;
            txshift  <= '0;
        end else begin
            FRAMEEND <= 1'b0;
            if (CLRFLAGS) begin
                OVR <= 1'b0;
                UDR <= 1'b0;
            end
            if (RXACK) begin
                RXVALID <= 1'b0;
            end
            if (load_req && empty) begin
                UDR <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (nss_fall) begin
                        state   <= SHIFT;
                        txshift <= load_byte[6:0];
                        MISO    <= load_byte[7];
                        MISO_OE <= 1'b1;
                        bitcnt  <= '0;
                        reload  <= 1'b0;
                        rxshift <= '0;
                    end
                end
                SHIFT: begin
                    if (nss_rise) begin
                        state    <= IDLE;
                        MISO_OE  <= 1'b0;
                        FRAMEEND <= 1'b1;
                        bitcnt   <= '0;
                        reload   <= 1'b0;
                    end else if (lead) begin
                        rxshift <= {rxshift[5:0], mosi_bit};
                        bitcnt  <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            reload <= 1'b1;
                            // An ack in the completing cycle frees RXD for the new byte.
                            if (!RXVALID || RXACK) begin
                                RXD     <= {rxshift, mosi_bit};
                                RXVALID <= 1'b1;
                            end else begin
                                OVR <= 1'b1;
                            end
                        end
                    end else if (trail) begin
                        if (reload) begin
                            txshift <= load_byte[6:0];
                            MISO    <= load_byte[7];
                            reload  <= 1'b0;
                        end else begin
                            txshift <= {txshift[5:0], 1'b0};
                            MISO    <= txshift[6];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_responder.sv
// Directed bench: a CPOL=0 and a CPOL=1 responder share one bit-banged initiator
// (SCK inverted for the second); single-byte frames are table driven.
module tb_spi_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       nreset, sck, sck_b, mosi, nss, rxack, txwr, clrflags;
    logic [7:0] txd;
    assign sck_b = ~sck;

    logic       miso_a, oe_a, rxv_a, txfull_a, ovr_a, udr_a, sel_a, fe_a;
    logic [7:0] rxd_a;
    logic [2:0] lvl_a;
    logic       miso_b, oe_b, rxv_b, txfull_b, ovr_b, udr_b, sel_b, fe_b;
    logic [7:0] rxd_b;
    logic [2:0] lvl_b;

    spi_responder #(.CPOL(1'b0), .TXLOG2(2), .FILL(8'hFF)) dut_a (
        .CLK(clk), .nRESET(nreset), .SCK(sck), .MOSI(mosi), .nSS(nss),
        .MISO(miso_a), .MISO_OE(oe_a), .RXD(rxd_a), .RXVALID(rxv_a), .RXACK(rxack),
        .TXD(txd), .TXWR(txwr), .TXFULL(txfull_a), .TXLEVEL(lvl_a),
        .OVR(ovr_a), .UDR(udr_a), .CLRFLAGS(clrflags), .SELECTED(sel_a), .FRAMEEND(fe_a)
    );

    spi_responder #(.CPOL(1'b1), .TXLOG2(2), .FILL(8'hFF)) dut_b (
        .CLK(clk), .nRESET(nreset), .SCK(sck_b), .MOSI(mosi), .nSS(nss),
        .MISO(miso_b), .MISO_OE(oe_b), .RXD(rxd_b), .RXVALID(rxv_b), .RXACK(rxack),
        .TXD(txd), .TXWR(txwr), .TXFULL(txfull_b), .TXLEVEL(lvl_b),
        .OVR(ovr_b), .UDR(udr_b), .CLRFLAGS(clrflags), .SELECTED(sel_b), .FRAMEEND(fe_b)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] mosi_bytes [8];
    logic [7:0] got_a [8];
    logic [7:0] got_b [8];
    logic [7:0] rx_got [8];
    logic       oe_before, oe_after, sel_before;
    int         fe_cnt_a = 0;
    int         fe_cnt_b = 0;

    always @(negedge clk) begin
        if (fe_a) fe_cnt_a++;
        if (fe_b) fe_cnt_b++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] d);
        txd  = d;
        txwr = 1'b1;
        clk_n(1);
        txwr = 1'b0;
    endtask

    task automatic pulse_clr();
        clrflags = 1'b1;
        clk_n(1);
        clrflags = 1'b0;
    endtask

    task automatic pulse_ack();
        rxack = 1'b1;
        clk_n(1);
        rxack = 1'b0;
        clk_n(1);
    endtask

    // mode 0: no ack, 1: ack after each byte completes, 2: ack in the completing cycle.
    // merge_end raises nSS together with the final SCK return to idle.
    task automatic frame(input int nbits, input int mode, input bit merge_end);
        nss = 1'b0;
        for (int k = 0; k < nbits; k++) begin
            int by;
            int bi;
            by   = k / 8;
            bi   = 7 - (k % 8);
            mosi = mosi_bytes[by][bi];
            clk_n(8);
            got_a[by][bi] = miso_a;
            got_b[by][bi] = miso_b;
            sck = 1'b1;
            if (bi == 0 && mode == 1) begin
                clk_n(5);
                rx_got[by] = rxd_a;
                rxack = 1'b1;
                clk_n(1);
                rxack = 1'b0;
                clk_n(2);
            end else if (bi == 0 && mode == 2) begin
                clk_n(2);
                rxack = 1'b1;
                clk_n(1);
                rxack = 1'b0;
                clk_n(5);
            end else begin
                clk_n(8);
            end
            if (!(merge_end && k == nbits - 1)) sck = 1'b0;
        end
        if (!merge_end) clk_n(8);
        oe_before  = oe_a;
        sel_before = sel_a;
        sck = 1'b0;
        nss = 1'b1;
        clk_n(4);
        oe_after = oe_a;
        clk_n(8);
    endtask

    typedef struct {
        logic [7:0] tx;
        bit         has_tx;
        logic [7:0] mosi;
        logic [7:0] miso_exp;
        bit         udr_exp;
    } vec_t;

    vec_t vt [4];

    initial begin
        int fe0, fe0b;

        vt[0] = '{tx: 8'hA5, has_tx: 1'b1, mosi: 8'h3C, miso_exp: 8'hA5, udr_exp: 1'b0};
        vt[1] = '{tx: 8'h00, has_tx: 1'b0, mosi: 8'h81, miso_exp: 8'hFF, udr_exp: 1'b1};
        vt[2] = '{tx: 8'h5A, has_tx: 1'b1, mosi: 8'hFF, miso_exp: 8'h5A, udr_exp: 1'b0};
        vt[3] = '{tx: 8'hC3, has_tx: 1'b1, mosi: 8'h00, miso_exp: 8'hC3, udr_exp: 1'b0};

        nreset = 1'b0; sck = 1'b0; mosi = 1'b0; nss = 1'b1;
        rxack = 1'b0; txwr = 1'b0; clrflags = 1'b0; txd = '0;
        clk_n(3);
        chk("rst_miso", miso_a, 1);
        chk("rst_oe", oe_a, 0);
        chk("rst_rxvalid", rxv_a, 0);
        chk("rst_rxd", rxd_a, 0);
        chk("rst_level", lvl_a, 0);
        chk("rst_sel", sel_a, 0);
        chk("rst_miso_b", miso_b, 1);
        nreset = 1'b1;
        clk_n(5);

        // Single-byte frames on both polarities
        for (int i = 0; i < 4; i++) begin
            pulse_clr();
            if (vt[i].has_tx) push(vt[i].tx);
            chk("pre_level", lvl_a, {31'd0, vt[i].has_tx});
            fe0  = fe_cnt_a;
            fe0b = fe_cnt_b;
            mosi_bytes[0] = vt[i].mosi;
            frame(8, 0, 1'b1);
            chk("v_miso_a", got_a[0], vt[i].miso_exp);
            chk("v_miso_b", got_b[0], vt[i].miso_exp);
            chk("v_rxd_a", rxd_a, vt[i].mosi);
            chk("v_rxd_b", rxd_b, vt[i].mosi);
            chk("v_rxvalid", rxv_a, 1);
            chk("v_level", lvl_a, 0);
            chk("v_udr_a", udr_a, {31'd0, vt[i].udr_exp});
            chk("v_udr_b", udr_b, {31'd0, vt[i].udr_exp});
            chk("v_frameend_a", fe_cnt_a - fe0, 1);
            chk("v_frameend_b", fe_cnt_b - fe0b, 1);
            chk("v_oe_during", oe_before, 1);
            chk("v_sel_during", sel_before, 1);
            chk("v_oe_after", oe_after, 0);
            chk("v_sel_after", sel_a, 0);
            pulse_ack();
            chk("v_ack", rxv_a, 0);
        end

        // Back-to-back bytes with acks; third byte underruns
        pulse_clr();
        push(8'h11);
        push(8'h22);
        mosi_bytes[0] = 8'h01; mosi_bytes[1] = 8'h02; mosi_bytes[2] = 8'h03;
        frame(24, 1, 1'b1);
        chk("b2b_miso0", got_a[0], 8'h11);
        chk("b2b_miso1", got_a[1], 8'h22);
        chk("b2b_miso2", got_a[2], 8'hFF);
        chk("b2b_rx0", rx_got[0], 8'h01);
        chk("b2b_rx1", rx_got[1], 8'h02);
        chk("b2b_rx2", rx_got[2], 8'h03);
        chk("b2b_udr", udr_a, 1);
        chk("b2b_rxvalid", rxv_a, 0);
        chk("b2b_ovr", ovr_a, 0);

        // Overrun, flag clear, ack coincident with completion
        pulse_clr();
        mosi_bytes[0] = 8'h55; mosi_bytes[1] = 8'hAA;
        frame(16, 0, 1'b1);
        chk("ovr_rxd", rxd_a, 8'h55);
        chk("ovr_set", ovr_a, 1);
        chk("ovr_rxvalid", rxv_a, 1);
        pulse_clr();
        chk("ovr_clr", ovr_a, 0);
        chk("udr_clr", udr_a, 0);
        mosi_bytes[0] = 8'hC3;
        frame(8, 2, 1'b1);
        chk("coack_rxd", rxd_a, 8'hC3);
        chk("coack_rxvalid", rxv_a, 1);
        chk("coack_ovr", ovr_a, 0);

        // Aborted frame after 5 SCK cycles, then a clean byte
        mosi_bytes[0] = 8'hF0;
        frame(5, 0, 1'b0);
        chk("abort_rxvalid", rxv_a, 1);
        chk("abort_rxd", rxd_a, 8'hC3);
        chk("abort_oe_before", oe_before, 1);
        chk("abort_oe_after", oe_after, 0);
        chk("abort_ovr", ovr_a, 0);
        pulse_ack();
        mosi_bytes[0] = 8'h7E;
        frame(8, 0, 1'b1);
        chk("after_abort_rxd", rxd_a, 8'h7E);
        chk("after_abort_rxd_b", rxd_b, 8'h7E);
        chk("after_abort_rxvalid", rxv_a, 1);
        pulse_ack();

        // FIFO fill past full
        pulse_clr();
        for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
        chk("full_level", lvl_a, 4);
        chk("full_flag", txfull_a, 1);
        for (int i = 0; i < 4; i++) mosi_bytes[i] = 8'h00;
        frame(32, 1, 1'b1);
        for (int i = 0; i < 4; i++) chk("full_miso", got_a[i], 8'h10 + 8'(i));
        chk("full_level_after", lvl_a, 0);
        chk("full_flag_after", txfull_a, 0);
        chk("full_udr", udr_a, 0);

        // Reset mid-byte with nSS held low, then a frame starts on release
        push(8'h99);
        mosi_bytes[0] = 8'h96;
        nss = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mosi = mosi_bytes[0][7 - k];
            clk_n(8);
            sck = 1'b1;
            clk_n(8);
            sck = 1'b0;
        end
        clk_n(2);
        chk("mid_oe", oe_a, 1);
        nreset = 1'b0;
        clk_n(3);
        chk("mrst_miso", miso_a, 1);
        chk("mrst_oe", oe_a, 0);
        chk("mrst_rxvalid", rxv_a, 0);
        chk("mrst_rxd", rxd_a, 0);
        chk("mrst_level", lvl_a, 0);
        chk("mrst_full", txfull_a, 0);
        chk("mrst_ovr", ovr_a, 0);
        chk("mrst_udr", udr_a, 0);
        chk("mrst_sel", sel_a, 0);
        chk("mrst_fe", fe_a, 0);
        chk("mrst_oe_b", oe_b, 0);
        nreset = 1'b1;
        frame(8, 0, 1'b1);
        chk("postrst_rxd", rxd_a, 8'h96);
        chk("postrst_rxd_b", rxd_b, 8'h96);
        chk("postrst_rxvalid", rxv_a, 1);
        chk("postrst_miso", got_a[0], 8'hFF);
        chk("postrst_udr", udr_a, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
